// File: rtl/alu_seq_if.sv
// Request/response and ALU-side bus of the ALU sequencer.
// The sequencer is the slave; the requester, which also hosts the
// combinational ALU, is the master.
interface alu_seq_if;
  // request side
  logic        start;
  logic [4:0]  op;
  logic        byte_m;     // byte-mode qualifier ("byte" is a keyword)
  logic [15:0] src;
  logic [15:0] dst;
  logic [5:0]  cnt;
  logic [3:0]  psw_in;
  // ALU strobe/operands
  logic [23:0] alu_op;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic        alu_ci;
  logic        alu_ni;
  logic        alu_byte;
  // ALU combinational response
  logic [15:0] alu_result;
  logic [3:0]  alu_flags;
  logic [3:0]  alu_ccmask;
  // status/result
  logic        busy;
  logic        done;
  logic        res_we;
  logic        err;
  logic [15:0] result;
  logic [3:0]  psw_out;

  modport slave (
    input  start, op, byte_m, src, dst, cnt, psw_in,
    input  alu_result, alu_flags, alu_ccmask,
    output alu_op, alu_in1, alu_in2, alu_ci, alu_ni, alu_byte,
    output busy, done, res_we, err, result, psw_out
  );

  modport master (
    output start, op, byte_m, src, dst, cnt, psw_in,
    output alu_result, alu_flags, alu_ccmask,
    input  alu_op, alu_in1, alu_in2, alu_ci, alu_ni, alu_byte,
    input  busy, done, res_we, err, result, psw_out
  );
endinterface

// File: rtl/alu_seq.sv
// ALU sequencer: issues one strobe to an external combinational ALU for
// single ops, or iterates asl/asr steps for the multi-bit ASH shift.
module alu_seq (
  input  logic      clk,
  input  logic      reset_n,
  alu_seq_if.slave  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] OP_TST = 5'd11;
  localparam logic [4:0] OP_ASR = 5'd14;
  localparam logic [4:0] OP_ASL = 5'd15;
  localparam logic [4:0] OP_MOV = 5'd17;
  localparam logic [4:0] OP_CMP = 5'd18;
  localparam logic [4:0] OP_BIT = 5'd19;
  localparam logic [4:0] OP_ASH = 5'd24;

  logic [1:0]  state_q, state_d;
  logic [4:0]  op_q;
  logic        byte_q;
  logic [15:0] src_q, dst_q;
  logic        dir_q;      // 1: shift right (negative count)
  logic [3:0]  psw_q;
  logic [15:0] work_q;
  logic [5:0]  step_q;     // remaining shift steps, up to 32
  logic        vacc_q;     // sign changed at some step so far
  logic [15:0] result_q;
  logic [3:0]  pswo_q;

  logic        req_illegal;
  logic [5:0]  cnt_abs;
  logic        illegal_q;
  logic        step_chg;

  assign req_illegal = (bus.op > OP_ASH);
  // -32 wraps to 6'b100000 which reads as 32 unsigned
  assign cnt_abs     = bus.cnt[5] ? (~bus.cnt + 6'd1) : bus.cnt;
  assign illegal_q   = (op_q > OP_ASH);
  assign step_chg    = bus.alu_result[15] ^ work_q[15];

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (req_illegal)
            state_d = S_DONE;
          else if (bus.op == OP_ASH && bus.cnt != 6'd0)
            state_d = S_SHIFT;
          else
            state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_SHIFT: if (step_q <= 6'd1) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive: a single one-hot strobe in EXEC/SHIFT, everything zero otherwise
  logic        strobe;
  logic [4:0]  sel;
  logic [23:0] alu_op_c;
  logic [15:0] in1_c, in2_c;
  logic        ci_c, ni_c, byte_c;

  always_comb begin
    strobe = 1'b0;
    sel    = 5'd0;
    in1_c  = 16'd0;
    in2_c  = 16'd0;
    ci_c   = 1'b0;
    ni_c   = 1'b0;
    byte_c = 1'b0;
    if (state_q == S_EXEC) begin
      strobe = 1'b1;
      // ASH with zero count is presented to the ALU as a word mov
      sel    = (op_q == OP_ASH) ? OP_MOV : op_q;
      in1_c  = src_q;
      in2_c  = dst_q;
      ci_c   = psw_q[0];
      ni_c   = psw_q[3];
      byte_c = (op_q == OP_ASH) ? 1'b0 : byte_q;
    end else if (state_q == S_SHIFT) begin
      strobe = 1'b1;
      sel    = dir_q ? OP_ASR : OP_ASL;
      in1_c  = src_q;
      in2_c  = work_q;
      ci_c   = psw_q[0];
      ni_c   = psw_q[3];
    end
    alu_op_c = '0;
    for (int i = 0; i < 24; i++)
      alu_op_c[i] = strobe && (sel == 5'(i));
  end

  assign bus.alu_op   = alu_op_c;
  assign bus.alu_in1  = in1_c;
  assign bus.alu_in2  = in2_c;
  assign bus.alu_ci   = ci_c;
  assign bus.alu_ni   = ni_c;
  assign bus.alu_byte = byte_c;

  // State, request latches, shift iteration and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      byte_q   <= 1'b0;
      src_q    <= '0;
      dst_q    <= '0;
      dir_q    <= 1'b0;
      psw_q    <= '0;
      work_q   <= '0;
      step_q   <= '0;
      vacc_q   <= 1'b0;
      result_q <= '0;
      pswo_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            byte_q <= bus.byte_m;
            src_q  <= bus.src;
            dst_q  <= bus.dst;
            dir_q  <= bus.cnt[5];
            psw_q  <= bus.psw_in;
            work_q <= bus.dst;
            step_q <= cnt_abs;
            vacc_q <= 1'b0;
            // illegal codes skip the ALU and report the operand unchanged
            if (req_illegal) begin
              result_q <= bus.dst;
              pswo_q   <= bus.psw_in;
            end
          end
        end
        S_EXEC: begin
          if (op_q == OP_ASH) begin
            result_q <= dst_q;
            pswo_q   <= {dst_q[15], (dst_q == 16'd0), 2'b00};
          end else begin
            result_q <= bus.alu_result;
            pswo_q   <= (bus.alu_ccmask & bus.alu_flags) | (~bus.alu_ccmask & psw_q);
          end
        end
        S_SHIFT: begin
          work_q <= bus.alu_result;
          vacc_q <= vacc_q | step_chg;
          step_q <= step_q - 6'd1;
          if (step_q <= 6'd1) begin
            result_q <= bus.alu_result;
            pswo_q   <= {bus.alu_result[15], (bus.alu_result == 16'd0),
                         vacc_q | step_chg, bus.alu_flags[0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.err     = (state_q == S_DONE) && illegal_q;
  assign bus.res_we  = (state_q == S_DONE) && !illegal_q &&
                       (op_q != OP_TST) && (op_q != OP_CMP) && (op_q != OP_BIT);
  assign bus.result  = result_q;
  assign bus.psw_out = pswo_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a small PDP-11 style ALU model.
module tb_alu_seq;
  logic clk;
  logic reset_n;
  int   nchk = 0;
  int   nerr = 0;

  alu_seq_if bus ();

  alu_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model for the codes exercised here
  always_comb begin
    logic [16:0] s;
    logic [15:0] r;
    s = '0;
    r = '0;
    bus.alu_result = '0;
    bus.alu_flags  = '0;
    bus.alu_ccmask = '0;
    if (bus.alu_op[0]) begin           // add
      s = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
      bus.alu_result = s[15:0];
      bus.alu_flags  = {s[15], (s[15:0] == 16'd0),
                        (bus.alu_in1[15] == bus.alu_in2[15]) && (s[15] != bus.alu_in1[15]), s[16]};
      bus.alu_ccmask = 4'hF;
    end else if (bus.alu_op[18]) begin // cmp: src - dst
      s = {1'b0, bus.alu_in1} - {1'b0, bus.alu_in2};
      bus.alu_result = s[15:0];
      bus.alu_flags  = {s[15], (s[15:0] == 16'd0),
                        (bus.alu_in1[15] != bus.alu_in2[15]) && (s[15] != bus.alu_in1[15]), s[16]};
      bus.alu_ccmask = 4'hF;
    end else if (bus.alu_op[4]) begin  // inc2: no flag update
      r = bus.alu_in2 + 16'd2;
      bus.alu_result = r;
      bus.alu_flags  = {r[15], (r == 16'd0), 2'b00};
      bus.alu_ccmask = 4'h0;
    end else if (bus.alu_op[15]) begin // asl
      r = {bus.alu_in2[14:0], 1'b0};
      bus.alu_result = r;
      bus.alu_flags  = {r[15], (r == 16'd0), r[15] ^ bus.alu_in2[15], bus.alu_in2[15]};
      bus.alu_ccmask = 4'hF;
    end else if (bus.alu_op[14]) begin // asr
      r = {bus.alu_in2[15], bus.alu_in2[15:1]};
      bus.alu_result = r;
      bus.alu_flags  = {r[15], (r == 16'd0), r[15] ^ bus.alu_in2[0], bus.alu_in2[0]};
      bus.alu_ccmask = 4'hF;
    end else if (bus.alu_op[17]) begin // mov
      bus.alu_result = bus.alu_in2;
      bus.alu_flags  = {bus.alu_in2[15], (bus.alu_in2 == 16'd0), 2'b00};
      bus.alu_ccmask = 4'hE;
    end
  end

  // Strobe monitor
  int n_asl, n_asr, n_strobe, bad_idle;
  always @(negedge clk) begin
    if (bus.alu_op == 24'h008000) n_asl++;
    if (bus.alu_op == 24'h004000) n_asr++;
    if (bus.alu_op != 24'h0) n_strobe++;
    if (!bus.busy && (bus.alu_op != 24'h0 || bus.alu_in1 != 16'h0 || bus.alu_in2 != 16'h0))
      bad_idle++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // First-cycle ALU drive snapshot
  logic [23:0] c1_op;
  logic [15:0] c1_in1, c1_in2;
  logic        c1_ci, c1_byte;

  // Issue one request; returns at the negedge of the done cycle.
  task automatic run(input logic [4:0] o, input logic b, input logic [15:0] s, d,
                     input logic [5:0] c, input logic [3:0] p, input logic poke,
                     output int lat);
    n_asl = 0; n_asr = 0; n_strobe = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.byte_m = b; bus.src = s; bus.dst = d;
    bus.cnt = c; bus.psw_in = p;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        c1_op = bus.alu_op; c1_in1 = bus.alu_in1; c1_in2 = bus.alu_in2;
        c1_ci = bus.alu_ci; c1_byte = bus.alu_byte;
      end
      if (poke) begin
        bus.start = 1'b1; bus.op = 5'd0; bus.src = 16'hAAAA; bus.dst = 16'h5555;
      end
      if (bus.done) break;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  int lat;
  int seen_done;

  initial begin
    reset_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.byte_m = 1'b0; bus.src = '0; bus.dst = '0;
    bus.cnt = '0; bus.psw_in = '0;
    #12;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 16'h0);
    chk("rst_psw", bus.psw_out, 4'h0);
    chk("rst_aluop", bus.alu_op, 24'h0);
    chk("rst_we_err", {bus.res_we, bus.err}, 2'b00);
    @(negedge clk) reset_n = 1'b1;

    // add with signed overflow
    run(5'd0, 1'b0, 16'h7FFF, 16'h0001, 6'd0, 4'b0000, 1'b0, lat);
    chk("add_lat", lat, 2);
    chk("add_result", bus.result, 16'h8000);
    chk("add_psw", bus.psw_out, 4'b1010);
    chk("add_we", bus.res_we, 1'b1);
    chk("add_err", bus.err, 1'b0);
    chk("add_c1_op", c1_op, 24'h000001);
    chk("add_c1_in", {c1_in1, c1_in2}, {16'h7FFF, 16'h0001});
    @(negedge clk);
    chk("add_done_1cyc", {bus.done, bus.busy}, 2'b00);
    chk("add_hold", bus.result, 16'h8000);

    // cmp: flags only, no write-back
    run(5'd18, 1'b0, 16'h0005, 16'h0005, 6'd0, 4'b0001, 1'b0, lat);
    chk("cmp_lat", lat, 2);
    chk("cmp_psw", bus.psw_out, 4'b0100);
    chk("cmp_we", bus.res_we, 1'b0);
    chk("cmp_ci", c1_ci, 1'b1);

    // inc2: ALU masks all flags, latched psw survives
    run(5'd4, 1'b1, 16'h0000, 16'h1000, 6'd0, 4'b1111, 1'b0, lat);
    chk("inc2_result", bus.result, 16'h1002);
    chk("inc2_psw", bus.psw_out, 4'b1111);
    chk("inc2_we", bus.res_we, 1'b1);
    chk("inc2_byte", c1_byte, 1'b1);

    // ASH +3
    run(5'd24, 1'b1, 16'h0000, 16'h1001, 6'd3, 4'b0000, 1'b0, lat);
    chk("ash3_lat", lat, 4);
    chk("ash3_result", bus.result, 16'h8008);
    chk("ash3_psw", bus.psw_out, 4'b1010);
    chk("ash3_nasl", n_asl, 3);
    chk("ash3_nstrobe", n_strobe, 3);
    chk("ash3_byte", c1_byte, 1'b0);

    // ASH -32 with start held during busy and at done
    run(5'd24, 1'b0, 16'h0000, 16'h8000, 6'h20, 4'b0000, 1'b1, lat);
    chk("ash32_lat", lat, 33);
    chk("ash32_result", bus.result, 16'hFFFF);
    chk("ash32_psw", bus.psw_out, 4'b1001);
    chk("ash32_nasr", n_asr, 32);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("ash32_start_at_done_ignored", bus.busy, 1'b0);

    // illegal code
    run(5'd27, 1'b0, 16'h0000, 16'h1234, 6'd0, 4'b0110, 1'b0, lat);
    chk("ill_lat", lat, 1);
    chk("ill_err", bus.err, 1'b1);
    chk("ill_result", bus.result, 16'h1234);
    chk("ill_psw", bus.psw_out, 4'b0110);
    chk("ill_we", bus.res_we, 1'b0);
    chk("ill_nstrobe", n_strobe, 0);

    // ASH with zero count on zero operand
    run(5'd24, 1'b1, 16'h0000, 16'h0000, 6'd0, 4'b1111, 1'b0, lat);
    chk("ash0_lat", lat, 2);
    chk("ash0_psw", bus.psw_out, 4'b0100);
    chk("ash0_result", bus.result, 16'h0000);
    chk("ash0_op_mov", c1_op, 24'h020000);
    chk("ash0_byte", c1_byte, 1'b0);
    chk("ash0_we", bus.res_we, 1'b1);

    // reset during step 5 of ASH +10
    @(negedge clk);
    bus.start = 1'b1; bus.op = 5'd24; bus.dst = 16'h0001; bus.cnt = 6'd10; bus.psw_in = 4'b0000;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_result", bus.result, 16'h0);
    chk("abort_psw", bus.psw_out, 4'h0);
    chk("abort_aluop", bus.alu_op, 24'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    run(5'd0, 1'b0, 16'h0001, 16'h0002, 6'd0, 4'b0000, 1'b0, lat);
    chk("post_lat", lat, 2);
    chk("post_result", bus.result, 16'h0003);
    chk("post_psw", bus.psw_out, 4'b0000);
    @(negedge clk);
    chk("idle_alu_quiet", bad_idle, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
